// File: rtl/rgmii_tx_decoder.sv
// RGMII transmit-path decoder: DDR TD/TX_CTL pairs in, GMII byte stream out (1G direct, 10/100 nibble pairing).
// Optional statistics counters are enabled with the RGMII_DEC_STATS_EN macro.
module rgmii_tx_decoder #(
  parameter int MAX_PRE_NIBBLES = 24
`ifdef RGMII_DEC_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       speed,
  input  logic [3:0]       rgmii_d1,
  input  logic             rgmii_ctl1,
  input  logic [3:0]       rgmii_d2,
  input  logic             rgmii_ctl2,
  output logic [7:0]       gmii_rxd,
  output logic             gmii_rx_dv,
  output logic             gmii_rx_er,
  output logic             gmii_rx_valid,
  output logic             sfd_err,
  output logic             odd_nibble_err,
  output logic             ddr_mismatch
`ifdef RGMII_DEC_STATS_EN
  , output logic [CNT_W-1:0] frame_count
  , output logic [CNT_W-1:0] err_count
`endif
);

  typedef enum logic [2:0] {IDLE, PRE, DATA_LO, DATA_HI, DRAIN} state_t;

  localparam int PRE_W = $clog2(MAX_PRE_NIBBLES + 1) + 1;

  state_t           state;
  logic             phase;
  logic [PRE_W-1:0] pre_cnt;
  logic             last5;
  logic [3:0]       lo;
  logic             er_hold;
  logic             en_q;
  logic [1:0]       mode_q;

  logic       en, er, is_1g, mismatch, speed_chg;
  logic [1:0] mode;

  assign en        = rgmii_ctl1;
  assign er        = rgmii_ctl1 ^ rgmii_ctl2;
  assign is_1g     = speed[1];
  assign mode      = speed[1] ? 2'b10 : speed;
  assign mismatch  = (rgmii_d1 != rgmii_d2) || (rgmii_ctl1 != rgmii_ctl2);
  // A mode change only matters while a frame (or its drain) is in flight.
  assign speed_chg = (mode != mode_q) && (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      phase          <= 1'b0;
      pre_cnt        <= '0;
      last5          <= 1'b0;
      lo             <= 4'h0;
      er_hold        <= 1'b0;
      en_q           <= 1'b1;  // a TX_EN held high through reset must not look like a frame start
      mode_q         <= 2'b10;
      gmii_rxd       <= 8'h00;
      gmii_rx_dv     <= 1'b0;
      gmii_rx_er     <= 1'b0;
      gmii_rx_valid  <= 1'b0;
      sfd_err        <= 1'b0;
      odd_nibble_err <= 1'b0;
      ddr_mismatch   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees this cycle's register values.
      gmii_rxd       <= 8'h00;
      gmii_rx_dv     <= 1'b0;
      gmii_rx_er     <= 1'b0;
      gmii_rx_valid  <= 1'b0;
      sfd_err        <= 1'b0;
      odd_nibble_err <= 1'b0;
      ddr_mismatch   <= !is_1g && mismatch;
      en_q           <= en;
      mode_q         <= mode;

      if (speed_chg) begin
        state <= DRAIN;
      end else if (is_1g) begin
        phase <= 1'b0;
        if (state == DRAIN) begin
          if (!en) state <= IDLE;
        end else begin
          gmii_rxd      <= {rgmii_d2, rgmii_d1};
          gmii_rx_dv    <= en;
          gmii_rx_er    <= er;
          gmii_rx_valid <= 1'b1;
          state         <= IDLE;
        end
      end else begin
        case (state)
          IDLE: begin
            if (en && !en_q) begin
              state   <= PRE;
              phase   <= 1'b0;
              pre_cnt <= PRE_W'(1);
              last5   <= (rgmii_d1 == 4'h5);
            end else begin
              phase <= ~phase;
              if (!phase) begin
                lo      <= rgmii_d1;
                er_hold <= er;
              end else begin
                gmii_rxd      <= {rgmii_d1, lo};
                gmii_rx_er    <= er_hold | er;
                gmii_rx_valid <= 1'b1;
              end
            end
          end
          PRE: begin
            if (!en) begin
              sfd_err <= 1'b1;
              state   <= IDLE;
              phase   <= 1'b0;
            end else if (rgmii_d1 == 4'h5) begin
              if (pre_cnt >= PRE_W'(MAX_PRE_NIBBLES)) begin
                sfd_err <= 1'b1;
                state   <= DRAIN;
              end else begin
                pre_cnt <= pre_cnt + 1'b1;
                last5   <= 1'b1;
                phase   <= ~phase;
                if (!phase) begin
                  er_hold <= er;
                end else begin
                  gmii_rxd      <= 8'h55;
                  gmii_rx_dv    <= 1'b1;
                  gmii_rx_er    <= er_hold | er;
                  gmii_rx_valid <= 1'b1;
                end
              end
            end else if (rgmii_d1 == 4'hD && last5) begin
              // SFD restarts byte pairing from the next nibble, whatever the preamble phase was.
              gmii_rxd      <= 8'hD5;
              gmii_rx_dv    <= 1'b1;
              gmii_rx_er    <= er;
              gmii_rx_valid <= 1'b1;
              state         <= DATA_LO;
            end else begin
              sfd_err <= 1'b1;
              state   <= DRAIN;
            end
          end
          DATA_LO: begin
            if (en) begin
              lo      <= rgmii_d1;
              er_hold <= er;
              state   <= DATA_HI;
            end else begin
              state <= IDLE;
              phase <= 1'b0;
            end
          end
          DATA_HI: begin
            gmii_rx_dv    <= 1'b1;
            gmii_rx_valid <= 1'b1;
            if (en) begin
              gmii_rxd   <= {rgmii_d1, lo};
              gmii_rx_er <= er_hold | er;
              state      <= DATA_LO;
            end else begin
              gmii_rxd       <= {4'h0, lo};
              gmii_rx_er     <= 1'b1;
              odd_nibble_err <= 1'b1;
              state          <= IDLE;
              phase          <= 1'b0;
            end
          end
          DRAIN: begin
            if (!en) begin
              state <= IDLE;
              phase <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef RGMII_DEC_STATS_EN
  logic frame_end;
  assign frame_end = !is_1g && !speed_chg && !en && (state == DATA_LO || state == DATA_HI);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      if (frame_end && !(&frame_count)) frame_count <= frame_count + 1'b1;
      if ((sfd_err || odd_nibble_err || ddr_mismatch) && !(&err_count))
        err_count <= err_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rgmii_tx_decoder.sv
// Self-checking bench for rgmii_tx_decoder: vector table with hand-computed responses plus reset sequences.
module tb_rgmii_tx_decoder;

  localparam logic [1:0] G1   = 2'b10;
  localparam logic [1:0] M100 = 2'b01;
  localparam logic [1:0] M10  = 2'b00;

  // Output bundle: {valid, dv, er, sfd_err, odd_nibble_err, ddr_mismatch, rxd}
  localparam logic [13:0] NONE  = 14'h0000;
  localparam logic [13:0] SFD_B = 14'h0400;
  localparam logic [13:0] ODD_B = 14'h0200;
  localparam logic [13:0] MM_B  = 14'h0100;

  typedef struct {
    logic [1:0]  speed;
    logic [3:0]  d1;
    logic        ctl1;
    logic [3:0]  d2;
    logic        ctl2;
    logic [13:0] exp;
    string       tag;
  } vec_t;

  logic       clk, rst;
  logic [1:0] speed;
  logic [3:0] rgmii_d1, rgmii_d2;
  logic       rgmii_ctl1, rgmii_ctl2;
  logic [7:0] gmii_rxd;
  logic       gmii_rx_dv, gmii_rx_er, gmii_rx_valid;
  logic       sfd_err, odd_nibble_err, ddr_mismatch;
`ifdef RGMII_DEC_STATS_EN
  logic [15:0] frame_count, err_count;
`endif

  rgmii_tx_decoder dut (
    .clk            (clk),
    .rst            (rst),
    .speed          (speed),
    .rgmii_d1       (rgmii_d1),
    .rgmii_ctl1     (rgmii_ctl1),
    .rgmii_d2       (rgmii_d2),
    .rgmii_ctl2     (rgmii_ctl2),
    .gmii_rxd       (gmii_rxd),
    .gmii_rx_dv     (gmii_rx_dv),
    .gmii_rx_er     (gmii_rx_er),
    .gmii_rx_valid  (gmii_rx_valid),
    .sfd_err        (sfd_err),
    .odd_nibble_err (odd_nibble_err),
    .ddr_mismatch   (ddr_mismatch)
`ifdef RGMII_DEC_STATS_EN
    , .frame_count  (frame_count)
    , .err_count    (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t  tbl[$];
  string cur_tag;
  int    pass_cnt = 0;
  int    total_cnt = 0;

  function automatic logic [13:0] byt(input logic [7:0] rxd, input logic dv, input logic er);
    return {1'b1, dv, er, 3'b000, rxd};
  endfunction

  function automatic logic [13:0] outs();
    return {gmii_rx_valid, gmii_rx_dv, gmii_rx_er, sfd_err, odd_nibble_err, ddr_mismatch, gmii_rxd};
  endfunction

  task automatic add(input logic [1:0] sp, input logic [3:0] d1, input logic c1,
                     input logic [3:0] d2, input logic c2, input logic [13:0] exp);
    vec_t v;
    v.speed = sp; v.d1 = d1; v.ctl1 = c1; v.d2 = d2; v.ctl2 = c2; v.exp = exp; v.tag = cur_tag;
    tbl.push_back(v);
  endtask

  // Clean nibble-mode cycle: both DDR halves identical.
  task automatic nib(input logic [1:0] sp, input logic [3:0] d, input logic en, input logic [13:0] exp);
    add(sp, d, en, d, en, exp);
  endtask

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got {v,dv,er,sfd,odd,mm,rxd}=%b_%b_%b_%b_%b_%b_%h required %b_%b_%b_%b_%b_%b_%h",
                  name, act[13], act[12], act[11], act[10], act[9], act[8], act[7:0],
                  exp[13], exp[12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
  endtask

  initial begin
    logic [7:0] ib;

    // ---- build vector table ----
    cur_tag = "1g";
    add(G1, 4'h0, 1'b0, 4'h0, 1'b0, byt(8'h00, 1'b0, 1'b0));
    for (int i = 0; i < 64; i++) begin
      ib = 8'(i);
      add(G1, ib[3:0], 1'b1, ib[7:4], (i == 10) ? 1'b0 : 1'b1, byt(ib, 1'b1, i == 10));
    end
    add(G1, 4'h0, 1'b0, 4'h0, 1'b0, byt(8'h00, 1'b0, 1'b0));

    cur_tag = "100m_idle";
    nib(M100, 4'h0, 1'b0, NONE);
    nib(M100, 4'h0, 1'b0, byt(8'h00, 1'b0, 1'b0));
    add(M100, 4'hE, 1'b0, 4'hE, 1'b1, MM_B);
    add(M100, 4'hE, 1'b0, 4'hE, 1'b1, byt(8'hEE, 1'b0, 1'b1) | MM_B);

    cur_tag = "100m_frame";
    nib(M100, 4'h5, 1'b1, NONE);
    for (int k = 2; k <= 15; k++) nib(M100, 4'h5, 1'b1, (k % 2 == 1) ? byt(8'h55, 1'b1, 1'b0) : NONE);
    nib(M100, 4'hD, 1'b1, byt(8'hD5, 1'b1, 1'b0));
    nib(M100, 4'h1, 1'b1, NONE);
    nib(M100, 4'h2, 1'b1, byt(8'h21, 1'b1, 1'b0));
    nib(M100, 4'h3, 1'b1, NONE);
    nib(M100, 4'h4, 1'b1, byt(8'h43, 1'b1, 1'b0));
    nib(M100, 4'h0, 1'b0, NONE);
    nib(M100, 4'h0, 1'b0, NONE);
    nib(M100, 4'h0, 1'b0, byt(8'h00, 1'b0, 1'b0));

    cur_tag = "10m_odd";
    nib(M10, 4'h5, 1'b1, NONE);
    nib(M10, 4'h5, 1'b1, NONE);
    nib(M10, 4'hD, 1'b1, byt(8'hD5, 1'b1, 1'b0));
    nib(M10, 4'h7, 1'b1, NONE);
    nib(M10, 4'h0, 1'b0, byt(8'h07, 1'b1, 1'b1) | ODD_B);

    cur_tag = "100m_pre_overflow";
    nib(M100, 4'h5, 1'b1, NONE);
    for (int k = 2; k <= 30; k++) begin
      if (k == 25)          nib(M100, 4'h5, 1'b1, SFD_B);
      else if (k > 25)      nib(M100, 4'h5, 1'b1, NONE);
      else if (k % 2 == 1)  nib(M100, 4'h5, 1'b1, byt(8'h55, 1'b1, 1'b0));
      else                  nib(M100, 4'h5, 1'b1, NONE);
    end
    nib(M100, 4'h0, 1'b0, NONE);
    nib(M100, 4'h0, 1'b0, NONE);
    nib(M100, 4'h0, 1'b0, byt(8'h00, 1'b0, 1'b0));

    cur_tag = "100m_ddr_mismatch";
    nib(M100, 4'h5, 1'b1, NONE);
    add(M100, 4'h5, 1'b1, 4'hA, 1'b1, MM_B);
    nib(M100, 4'hD, 1'b1, byt(8'hD5, 1'b1, 1'b0));
    add(M100, 4'h3, 1'b1, 4'hF, 1'b1, MM_B);
    nib(M100, 4'h4, 1'b1, byt(8'h43, 1'b1, 1'b0));
    nib(M100, 4'h0, 1'b0, NONE);

    cur_tag = "100m_bad_pre_nibble";
    nib(M100, 4'h5, 1'b1, NONE);
    nib(M100, 4'h5, 1'b1, NONE);
    nib(M100, 4'h9, 1'b1, SFD_B);
    nib(M100, 4'h5, 1'b1, NONE);
    nib(M100, 4'h0, 1'b0, NONE);

    cur_tag = "100m_en_drop_in_pre";
    nib(M100, 4'h5, 1'b1, NONE);
    nib(M100, 4'h5, 1'b1, NONE);
    nib(M100, 4'h0, 1'b0, SFD_B);

    cur_tag = "speed_change_mid_frame";
    nib(M100, 4'h5, 1'b1, NONE);
    nib(M100, 4'h5, 1'b1, NONE);
    nib(M100, 4'hD, 1'b1, byt(8'hD5, 1'b1, 1'b0));
    nib(M100, 4'h1, 1'b1, NONE);
    add(G1, 4'h2, 1'b1, 4'h2, 1'b1, NONE);
    add(G1, 4'h2, 1'b1, 4'h2, 1'b1, NONE);
    add(G1, 4'h0, 1'b0, 4'h0, 1'b0, NONE);
    add(G1, 4'h3, 1'b0, 4'h4, 1'b0, byt(8'h43, 1'b0, 1'b0));

    // ---- reset ----
    rst = 1'b1; speed = G1;
    rgmii_d1 = 4'h0; rgmii_d2 = 4'h0; rgmii_ctl1 = 1'b0; rgmii_ctl2 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", outs(), NONE);
    rst = 1'b0;

    // ---- table ----
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      speed = tbl[i].speed;
      rgmii_d1 = tbl[i].d1; rgmii_ctl1 = tbl[i].ctl1;
      rgmii_d2 = tbl[i].d2; rgmii_ctl2 = tbl[i].ctl2;
      @(posedge clk); #1;
      check($sformatf("%s[%0d]", tbl[i].tag, i), outs(), tbl[i].exp);
    end

`ifdef RGMII_DEC_STATS_EN
    total_cnt++;
    if (frame_count === 16'd3) pass_cnt++;
    else $display("FAIL frame_count: got %0d required 3", frame_count);
`endif

    // ---- reset in the middle of a 1G frame ----
    @(negedge clk);
    speed = G1; rgmii_d1 = 4'h1; rgmii_d2 = 4'h2; rgmii_ctl1 = 1'b1; rgmii_ctl2 = 1'b1;
    @(posedge clk); #1;
    check("pre_reset_1g", outs(), byt(8'h21, 1'b1, 1'b0));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_reset_immediate", outs(), NONE);
    @(posedge clk); #1;
    check("reset_held_edge", outs(), NONE);

    // TX_EN still high after reset: no frame may start, so the pair shows as idle (dv=0).
    @(negedge clk);
    rst = 1'b0; speed = M100;
    rgmii_d1 = 4'h6; rgmii_d2 = 4'h6; rgmii_ctl1 = 1'b1; rgmii_ctl2 = 1'b1;
    @(posedge clk); #1;
    check("post_reset_no_start_0", outs(), NONE);
    @(posedge clk); #1;
    check("post_reset_no_start_1", outs(), byt(8'h66, 1'b0, 1'b0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
